// File: rtl/rs232c_pkg.sv
// Shared opcode constants, FSM state type and opcode decode helpers for rs232c_port.
// RS232C_PORT_WORD_EN adds the INPUTW/OUTPUTW word opcodes to the I/O decode.
package rs232c_pkg;

    localparam logic [5:0] INPUTW  = 6'b111100;
    localparam logic [5:0] INPUTB  = 6'b111101;
    localparam logic [5:0] OUTPUTB = 6'b111110;
    localparam logic [5:0] OUTPUTW = 6'b111111;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    function automatic logic is_word_op(input logic [5:0] op);
        return (op == INPUTW) || (op == OUTPUTW);
    endfunction

    function automatic logic is_io_op(input logic [5:0] op);
`ifdef RS232C_PORT_WORD_EN
        return (op == INPUTB) || (op == OUTPUTB) || is_word_op(op);
`else
        return (op == INPUTB) || (op == OUTPUTB);
`endif
    endfunction

    function automatic logic is_tx_op(input logic [5:0] op);
        return (op == OUTPUTB) || (op == OUTPUTW);
    endfunction

endpackage

// File: rtl/rs232c_word_shift.sv
// Word shift register for rs232c_port: picks the outgoing byte of a word transfer
// and assembles incoming bytes into a zero-extended word.
module rs232c_word_shift #(
    parameter int unsigned WORD_BYTES = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    localparam int unsigned BW        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          word,
    input  logic [BW-1:0] beat,
    input  logic          load,
    input  logic          insert,
    input  logic [31:0]   rt,
    input  logic [7:0]    rx_byte,
    output logic [7:0]    tx_byte,
    output logic [31:0]   rx_word
);

    logic [31:0] shreg;
    logic [31:0] src;
    logic [31:0] base;
    logic [BW:0] n;
    logic [BW:0] idx;
    logic [4:0]  bitpos;

    always_comb begin
        n      = word ? (BW+1)'(WORD_BYTES) : (BW+1)'(1);
        idx    = MSB_FIRST ? (n - (BW+1)'(1) - {1'b0, beat}) : {1'b0, beat};
        bitpos = {idx[1:0], 3'b000};
        // beat 0 reads rt directly, so the first byte leaves without waiting for the load
        src     = (beat == '0) ? rt : shreg;
        tx_byte = 8'(src >> bitpos);
        base    = (beat == '0) ? '0 : shreg;
        if (MSB_FIRST) begin
            rx_word = {base[23:0], rx_byte};
        end else begin
            rx_word = base | (32'(rx_byte) << bitpos);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (load && (beat == '0)) begin
            shreg <= rt;
        end else if (insert) begin
            shreg <= rx_word;
        end
    end

endmodule

// File: rtl/rs232c_port.sv
// RS232C instruction dispatcher: byte/word I/O between decode and UART FIFOs with stall.
// Word ops (INPUTW/OUTPUTW) are compiled in only when RS232C_PORT_WORD_EN is defined.
module rs232c_port
    import rs232c_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic [31:0] rt,
    input  logic        tx_ready,
    output logic        push_send_data,
    output logic [7:0]  send_data,
    input  logic        rx_wait,
    input  logic [7:0]  received_data,
    output logic        pop_received,
    output logic        stall,
    output logic        enable,
    output logic        float,
    output logic [4:0]  addr,
    output logic [31:0] data
);

    logic [5:0]  op;
    logic        op_io;
    logic        op_tx;
    logic        hs;
    logic        last;
    logic        tx_beat;
    logic        rx_beat;
    logic [7:0]  tx_byte;
    logic [31:0] rx_word;

    assign op      = inst[31:26];
    assign op_io   = is_io_op(op);
    assign op_tx   = is_tx_op(op);
    assign hs      = op_tx ? tx_ready : ~rx_wait;
    assign tx_beat = op_io & op_tx & hs;
    assign rx_beat = op_io & ~op_tx & hs;

    assign stall        = ~reset & op_io & ~(hs & last);
    assign pop_received = ~reset & rx_beat;
    assign float        = 1'b0;

    logic unused_inst;
    assign unused_inst = ^{inst[25:21], inst[15:0]};

`ifdef RS232C_PORT_WORD_EN
    localparam int unsigned BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    state_t        state;
    logic [BW-1:0] beat;
    logic          word;

    assign word = is_word_op(op);
    assign last = word ? (beat == BW'(WORD_BYTES - 1)) : 1'b1;

    rs232c_word_shift #(
        .WORD_BYTES (WORD_BYTES),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .word    (word),
        .beat    (beat),
        .load    (tx_beat),
        .insert  (rx_beat),
        .rt      (rt),
        .rx_byte (received_data),
        .tx_byte (tx_byte),
        .rx_word (rx_word)
    );

    // Leaving I/O decode mid-word is a flush: the partial word is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_io && hs && !last) begin
                        state <= XFER;
                        beat  <= BW'(1);
                    end
                end
                XFER: begin
                    if (!op_io) begin
                        state <= IDLE;
                        beat  <= '0;
                    end else if (hs) begin
                        if (last) begin
                            state <= IDLE;
                            beat  <= '0;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end
`else
    localparam int unsigned unused_cfg = WORD_BYTES + 32'(MSB_FIRST);

    logic unused_rt;
    assign unused_rt = ^rt[31:8];

    assign last    = 1'b1;
    assign tx_byte = rt[7:0];
    assign rx_word = {24'b0, received_data};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            push_send_data <= 1'b0;
            send_data      <= '0;
            enable         <= 1'b0;
            addr           <= '0;
            data           <= '0;
        end else begin
            push_send_data <= tx_beat;
            if (tx_beat) begin
                send_data <= tx_byte;
            end
            enable <= rx_beat & last;
            if (rx_beat && last) begin
                addr <= inst[20:16];
                data <= rx_word;
            end
        end
    end

endmodule

// File: tb/tb_rs232c_port.sv
// Self-checking bench for rs232c_port: directed scenarios plus a randomized run
// checked against a transaction-level model of the byte/word transfer rules.
module tb_rs232c_port;

    localparam logic [5:0] T_INPUTW  = 6'b111100;
    localparam logic [5:0] T_INPUTB  = 6'b111101;
    localparam logic [5:0] T_OUTPUTB = 6'b111110;
    localparam logic [5:0] T_OUTPUTW = 6'b111111;
    localparam int         WB        = 4;
`ifdef RS232C_PORT_WORD_EN
    localparam bit WORD_EN = 1'b1;
`else
    localparam bit WORD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic [31:0] rt;
    logic        tx_ready;
    logic        push_send_data;
    logic [7:0]  send_data;
    logic        rx_wait;
    logic [7:0]  received_data;
    logic        pop_received;
    logic        stall;
    logic        enable;
    logic        float;
    logic [4:0]  addr;
    logic [31:0] data;

    always #5 clk = ~clk;

    rs232c_port #(
        .WORD_BYTES (WB),
        .MSB_FIRST  (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inst           (inst),
        .rt             (rt),
        .tx_ready       (tx_ready),
        .push_send_data (push_send_data),
        .send_data      (send_data),
        .rx_wait        (rx_wait),
        .received_data  (received_data),
        .pop_received   (pop_received),
        .stall          (stall),
        .enable         (enable),
        .float          (float),
        .addr           (addr),
        .data           (data)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic        c_stall, c_pop, r_push, r_en, r_float;
    logic [7:0]  r_send;
    logic [4:0]  r_addr;
    logic [31:0] r_data;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] idx);
        return {op, 5'd0, idx, 16'h0000};
    endfunction

    // One clock: inputs applied just after the edge, combinational outputs sampled
    // at the falling edge, registered outputs sampled just after the next rising edge.
    task automatic step(input logic tr, input logic rw, input logic [7:0] rb);
        tx_ready      = tr;
        rx_wait       = rw;
        received_data = rb;
        #4;
        c_stall = stall;
        c_pop   = pop_received;
        @(posedge clk);
        #1;
        r_push  = push_send_data;
        r_send  = send_data;
        r_en    = enable;
        r_addr  = addr;
        r_data  = data;
        r_float = float;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inst  = mk(T_INPUTB, 5'd3);
        rt    = 32'hFFFF_FFFF;
        step(1'b1, 1'b0, 8'h55);
        n_cmp += 3;
        if (c_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b want=0", c_stall); end
        if (c_pop !== 1'b0) begin n_err++; $display("FAIL reset_pop got=%b want=0", c_pop); end
        if (r_float !== 1'b0) begin n_err++; $display("FAIL reset_float got=%b want=0", r_float); end
        inst = mk(T_OUTPUTB, 5'd0);
        step(1'b1, 1'b0, 8'h55);
        n_cmp += 6;
        if (c_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall_tx got=%b want=0", c_stall); end
        if (r_push !== 1'b0) begin n_err++; $display("FAIL reset_push got=%b want=0", r_push); end
        if (r_send !== 8'h00) begin n_err++; $display("FAIL reset_send got=%h want=00", r_send); end
        if (r_en !== 1'b0) begin n_err++; $display("FAIL reset_enable got=%b want=0", r_en); end
        if (r_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr got=%0d want=0", r_addr); end
        if (r_data !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h want=0", r_data); end
        reset = 1'b0;
        inst  = 32'h0;
        step(1'b1, 1'b1, 8'h00);
    endtask

    task automatic test_outputb();
        inst = mk(T_OUTPUTB, 5'd0);
        rt   = 32'h0000_00A5;
        step(1'b1, 1'b1, 8'h00);
        n_cmp += 3;
        if (c_stall !== 1'b0) begin n_err++; $display("FAIL outb_stall got=%b want=0", c_stall); end
        if (r_push !== 1'b1) begin n_err++; $display("FAIL outb_push got=%b want=1", r_push); end
        if (r_send !== 8'hA5) begin n_err++; $display("FAIL outb_data got=%h want=a5", r_send); end
        rt = 32'h1234_565A;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00);
            n_cmp += 2;
            if (c_stall !== 1'b1) begin n_err++; $display("FAIL outb_wait_stall got=%b want=1", c_stall); end
            if (r_push !== 1'b0) begin n_err++; $display("FAIL outb_wait_push got=%b want=0", r_push); end
        end
        step(1'b1, 1'b0, 8'h00);
        n_cmp += 3;
        if (c_stall !== 1'b0) begin n_err++; $display("FAIL outb_go_stall got=%b want=0", c_stall); end
        if (r_push !== 1'b1) begin n_err++; $display("FAIL outb_go_push got=%b want=1", r_push); end
        if (r_send !== 8'h5A) begin n_err++; $display("FAIL outb_go_data got=%h want=5a", r_send); end
        inst = 32'h0;
        step(1'b1, 1'b0, 8'h00);
        n_cmp += 1;
        if (r_push !== 1'b0) begin n_err++; $display("FAIL outb_pulse got=%b want=0", r_push); end
    endtask

    task automatic test_inputb_wait();
        int stalls = 0;
        inst = mk(T_INPUTB, 5'd9);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 8'hFF);
            if (c_stall) stalls++;
            n_cmp += 2;
            if (c_pop !== 1'b0) begin n_err++; $display("FAIL inb_wait_pop got=%b want=0", c_pop); end
            if (r_en !== 1'b0) begin n_err++; $display("FAIL inb_wait_en got=%b want=0", r_en); end
        end
        step(1'b0, 1'b0, 8'h3C);
        n_cmp += 6;
        if (stalls != 5) begin n_err++; $display("FAIL inb_stall_cycles got=%0d want=5", stalls); end
        if (c_stall !== 1'b0) begin n_err++; $display("FAIL inb_stall_end got=%b want=0", c_stall); end
        if (c_pop !== 1'b1) begin n_err++; $display("FAIL inb_pop got=%b want=1", c_pop); end
        if (r_en !== 1'b1) begin n_err++; $display("FAIL inb_en got=%b want=1", r_en); end
        if (r_addr !== 5'd9) begin n_err++; $display("FAIL inb_addr got=%0d want=9", r_addr); end
        if (r_data !== 32'h0000_003C) begin n_err++; $display("FAIL inb_data got=%h want=0000003c", r_data); end
        inst = 32'h0;
        step(1'b1, 1'b0, 8'h00);
        n_cmp += 1;
        if (r_en !== 1'b0) begin n_err++; $display("FAIL inb_pulse got=%b want=0", r_en); end
    endtask

`ifdef RS232C_PORT_WORD_EN
    task automatic test_outputw();
        logic [7:0] got[$];
        int stalls = 0;
        int cyc = 0;
        bit done = 1'b0;
        inst = mk(T_OUTPUTW, 5'd0);
        rt   = 32'h1122_3344;
        while (!done && cyc < 20) begin
            step(cyc != 1, 1'b1, 8'h00);
            if (c_stall) stalls++; else done = 1'b1;
            if (r_push) got.push_back(r_send);
            cyc++;
        end
        inst = 32'h0;
        step(1'b1, 1'b1, 8'h00);
        if (r_push) got.push_back(r_send);
        n_cmp += 3;
        if (!done) begin n_err++; $display("FAIL outw_timeout got=%0d cycles want<20", cyc); end
        if (stalls != 4) begin n_err++; $display("FAIL outw_stall_cycles got=%0d want=4", stalls); end
        if (got.size() != 4) begin n_err++; $display("FAIL outw_push_count got=%0d want=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== 8'(32'h1122_3344 >> (8 * (3 - i)))) begin
                n_err++; $display("FAIL outw_byte%0d got=%h want=%h", i, got[i], 8'(32'h1122_3344 >> (8 * (3 - i))));
            end
        end
    endtask

    task automatic test_inputw();
        logic [7:0] bytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        int pops = 0, ens = 0, stalls = 0, cyc = 0;
        logic [31:0] word = 32'h0;
        logic [4:0]  waddr = 5'd0;
        inst = mk(T_INPUTW, 5'd7);
        while (pops < 4 && cyc < 30) begin
            step(1'b0, (cyc % 3) == 1, bytes[pops]);
            if (c_stall) stalls++;
            if (c_pop) pops++;
            if (r_en) begin ens++; word = r_data; waddr = r_addr; end
            cyc++;
        end
        inst = 32'h0;
        step(1'b0, 1'b0, 8'h00);
        if (r_en) ens++;
        n_cmp += 5;
        if (pops != 4) begin n_err++; $display("FAIL inw_pops got=%0d want=4", pops); end
        if (ens != 1) begin n_err++; $display("FAIL inw_enables got=%0d want=1", ens); end
        if (waddr !== 5'd7) begin n_err++; $display("FAIL inw_addr got=%0d want=7", waddr); end
        if (word !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL inw_data got=%h want=deadbeef", word); end
        if (stalls != cyc - 1) begin n_err++; $display("FAIL inw_stall_cycles got=%0d want=%0d", stalls, cyc - 1); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got[$];
        int cyc = 0;
        inst = mk(T_OUTPUTW, 5'd0);
        rt   = 32'h1122_3344;
        step(1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h00);
        reset = 1'b1;
        step(1'b1, 1'b1, 8'h00);
        n_cmp += 3;
        if (c_stall !== 1'b0) begin n_err++; $display("FAIL rmid_stall got=%b want=0", c_stall); end
        if (r_push !== 1'b0) begin n_err++; $display("FAIL rmid_push got=%b want=0", r_push); end
        if (r_send !== 8'h00) begin n_err++; $display("FAIL rmid_send got=%h want=00", r_send); end
        reset = 1'b0;
        do begin
            step(1'b1, 1'b1, 8'h00);
            if (r_push) got.push_back(r_send);
            cyc++;
        end while (c_stall && cyc < 20);
        inst = 32'h0;
        n_cmp += 1;
        if (got.size() != 4) begin n_err++; $display("FAIL rmid_push_count got=%0d want=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== 8'(32'h1122_3344 >> (8 * (3 - i)))) begin
                n_err++; $display("FAIL rmid_byte%0d got=%h want=%h", i, got[i], 8'(32'h1122_3344 >> (8 * (3 - i))));
            end
        end
    endtask
`else
    task automatic test_word_disabled();
        inst = mk(T_OUTPUTW, 5'd0);
        rt   = 32'h1122_3344;
        step(1'b1, 1'b1, 8'h00);
        n_cmp += 2;
        if (c_stall !== 1'b0) begin n_err++; $display("FAIL nowd_outw_stall got=%b want=0", c_stall); end
        if (r_push !== 1'b0) begin n_err++; $display("FAIL nowd_outw_push got=%b want=0", r_push); end
        inst = mk(T_INPUTW, 5'd4);
        step(1'b0, 1'b0, 8'h77);
        n_cmp += 3;
        if (c_stall !== 1'b0) begin n_err++; $display("FAIL nowd_inw_stall got=%b want=0", c_stall); end
        if (c_pop !== 1'b0) begin n_err++; $display("FAIL nowd_inw_pop got=%b want=0", c_pop); end
        if (r_en !== 1'b0) begin n_err++; $display("FAIL nowd_inw_en got=%b want=0", r_en); end
        inst = 32'h0;
    endtask
`endif

    // Reference model: an instruction is N byte transfers; each handshake completes
    // one, stall drops on the handshake that completes the Nth. Words are MSB first.
    task automatic test_random();
        for (int t = 0; t < 80; t++) begin
            int kind = $urandom_range(0, 4);
            logic [5:0]  op;
            logic [4:0]  idx = 5'($urandom);
            logic [31:0] val = $urandom;
            bit io, tx, word;
            int n, done, cyc;
            logic [31:0] acc = 32'h0;
            case (kind)
                0: op = T_INPUTB;
                1: op = T_OUTPUTB;
                2: op = T_INPUTW;
                3: op = T_OUTPUTW;
                default: op = 6'($urandom_range(0, 59));
            endcase
            word = (kind == 2) || (kind == 3);
            tx   = (kind == 1) || (kind == 3);
            io   = (kind < 2) || (WORD_EN && word);
            n    = word ? WB : 1;
            inst = mk(op, idx);
            rt   = val;
            if (!io) begin
                step(1'($urandom), 1'($urandom), 8'($urandom));
                n_cmp += 4;
                if (c_stall !== 1'b0) begin n_err++; $display("FAIL rnd_nonio_stall op=%b got=%b want=0", op, c_stall); end
                if (c_pop !== 1'b0) begin n_err++; $display("FAIL rnd_nonio_pop op=%b got=%b want=0", op, c_pop); end
                if (r_push !== 1'b0) begin n_err++; $display("FAIL rnd_nonio_push op=%b got=%b want=0", op, r_push); end
                if (r_en !== 1'b0) begin n_err++; $display("FAIL rnd_nonio_en op=%b got=%b want=0", op, r_en); end
                continue;
            end
            done = 0;
            cyc  = 0;
            while (done < n && cyc < 100) begin
                bit hs = ($urandom_range(0, 2) != 0);
                bit other = 1'($urandom);
                logic [7:0] b = 8'($urandom);
                bit last = (done == n - 1);
                logic [7:0] exp_byte = 8'(val >> (8 * (n - 1 - done)));
                if (tx) step(hs, other, b); else step(other, !hs, b);
                n_cmp += 4;
                if (c_stall !== !(hs && last)) begin n_err++; $display("FAIL rnd_stall t=%0d op=%b got=%b want=%b", t, op, c_stall, !(hs && last)); end
                if (c_pop !== (!tx && hs)) begin n_err++; $display("FAIL rnd_pop t=%0d op=%b got=%b want=%b", t, op, c_pop, (!tx && hs)); end
                if (r_push !== (tx && hs)) begin n_err++; $display("FAIL rnd_push t=%0d op=%b got=%b want=%b", t, op, r_push, (tx && hs)); end
                if (tx && hs) begin
                    n_cmp++;
                    if (r_send !== exp_byte) begin n_err++; $display("FAIL rnd_send t=%0d beat=%0d got=%h want=%h", t, done, r_send, exp_byte); end
                end
                if (!tx && hs) acc = (acc << 8) | 32'(b);
                if (r_en !== (!tx && hs && last)) begin n_err++; $display("FAIL rnd_en t=%0d op=%b got=%b want=%b", t, op, r_en, (!tx && hs && last)); end
                if (!tx && hs && last) begin
                    n_cmp += 2;
                    if (r_data !== acc) begin n_err++; $display("FAIL rnd_data t=%0d got=%h want=%h", t, r_data, acc); end
                    if (r_addr !== idx) begin n_err++; $display("FAIL rnd_addr t=%0d got=%0d want=%0d", t, r_addr, idx); end
                end
                if (hs) done++;
                cyc++;
            end
            n_cmp++;
            if (done < n) begin n_err++; $display("FAIL rnd_timeout t=%0d got=%0d beats want=%0d", t, done, n); end
        end
        inst = 32'h0;
    endtask

    initial begin
        reset         = 1'b1;
        inst          = 32'h0;
        rt            = 32'h0;
        tx_ready      = 1'b0;
        rx_wait       = 1'b1;
        received_data = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_outputb();
        test_inputb_wait();
`ifdef RS232C_PORT_WORD_EN
        test_outputw();
        test_inputw();
        test_reset_mid();
`else
        test_word_disabled();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rs232c_port.md
# rs232c_port

Second-generation RS232C instruction dispatcher between the decode stage and the UART TX/RX byte FIFOs. Executes byte I/O (INPUTB/OUTPUTB) and multi-byte word I/O (INPUTW/OUTPUTW) with real flow control: stalls the pipeline while the UART cannot accept or supply bytes, and serialises or assembles words over several cycles. Integer register writeback uses the existing enable/addr/data port.

## Interface
- `INPUTB`, 6'b111101, byte input opcode
- `OUTPUTB`, 6'b111110, byte output opcode
- `INPUTW`, 6'b111100, word input opcode
- `OUTPUTW`, 6'b111111, word output opcode
- `WORD_BYTES`, 4, bytes per word op (2..4)
- `MSB_FIRST`, 1, 1: most significant byte transferred first; 0: least significant first
- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high
- `inst` in 32: current instruction; op = inst[31:26], rt index = inst[20:16]; held stable while `stall`=1
- `rt` in 32: rt register value
- `tx_ready` in 1: TX FIFO can accept a byte this cycle
- `push_send_data` out 1: registered push strobe to TX FIFO
- `send_data` out 8: byte pushed
- `rx_wait` in 1: RX FIFO empty
- `received_data` in 8: RX FIFO head byte
- `pop_received` out 1: combinational; RX head consumed at this edge
- `stall` out 1: combinational; freeze pipeline
- `enable` out 1: registered writeback strobe
- `float` out 1: constant 0
- `addr` out 5: writeback register
- `data` out 32: writeback value

## Operation
- States: IDLE, XFER; beat counter `beat` (clog2(WORD_BYTES) bits); 32-bit shift register `shreg`.
- Beat count N: 1 for B ops, WORD_BYTES for W ops. Beat k completes in a cycle where the handshake holds: TX ops need `tx_ready`=1, RX ops need `rx_wait`=0.
- `stall` = I/O op decoded AND NOT (handshake AND last beat). Non-I/O ops: `stall`=0.
- IDLE + I/O op: on first handshake, OUTPUT ops load `shreg` from `rt`; if N=1, transfer completes; otherwise → XFER, `beat`=1.
- XFER: each handshake advances `beat`; on beat N-1 → IDLE, `beat`=0.
- TX beat: `push_send_data`<=1, `send_data`<= the selected byte (MSB_FIRST: rt[8N-1-8k -: 8], else rt[8k +: 8]); OUTPUTB sends rt[7:0]. No handshake: `push_send_data`<=0.
- RX beat: `pop_received`=1; byte shifted into `shreg` (MSB_FIRST shifts left, else right-fills). On last beat: `enable`<=1, `addr`<=inst[20:16], `data`<= assembled word, zero-extended to 32 bits (INPUTB: {24'b0, byte}).
- Op leaves I/O decode while in XFER (flush): → IDLE, `beat`=0, partial word discarded; bytes already pushed/popped are not recovered.
- `enable`, `push_send_data` are 1-cycle pulses; otherwise 0.

## Timing
- Reset values: `push_send_data`=0, `send_data`=0, `enable`=0, `addr`=0, `data`=0, state IDLE, `beat`=0, `shreg`=0; `stall` and `pop_received` forced 0 while `reset`=1.
- Reset mid-XFER aborts; after release the held instruction restarts from beat 0.
- OUTPUTB with `tx_ready`=1: `stall`=0, push one cycle later (same as first-generation block).
- OUTPUTW, WORD_BYTES=4, `tx_ready` always 1: `stall` high 3 cycles, pushes in cycles 1..4 after issue.
- INPUTW: `enable` one cycle after the final pop; each missing byte adds one stall cycle.

## Configuration
- `RS232C_PORT_WORD_EN` defined: INPUTW/OUTPUTW, `beat`, `shreg`, XFER state compiled in.
- Undefined: only byte ops; INPUTW/OUTPUTW decode as non-I/O (no stall, no strobes); WORD_BYTES and MSB_FIRST ignored; block reduces to byte dispatcher with stall on `tx_ready`=0 / `rx_wait`=1.

## Structure
- `rs232c_pkg`: opcode constants, state enum (IDLE, XFER), `is_io_op`/`is_tx_op` decode functions.
- Sub-module `rs232c_word_shift`: `shreg`, byte select for TX, byte insert for RX, parametrised by WORD_BYTES and MSB_FIRST.

## Test plan
- OUTPUTB, rt=0x000000A5, `tx_ready`=1 → `stall`=0; next cycle push with `send_data`=0xA5.
- OUTPUTW, rt=0x11223344, MSB_FIRST=1, `tx_ready` low in 2nd cycle → pushes 0x11,0x22,0x33,0x44; `stall` high 4 cycles total.
- INPUTW to r7, RX supplies 0xDE,0xAD,0xBE,0xEF with `rx_wait` gaps → 4 pops; `enable`=1, `addr`=7, `data`=0xDEADBEEF once.
- INPUTB with `rx_wait`=1 for 5 cycles then byte 0x3C → stall 5 cycles; `data`=0x0000003C.
- `reset` asserted after 2nd beat of OUTPUTW → outputs reset; after release, word resent from 0x11.
- Build without `RS232C_PORT_WORD_EN`: OUTPUTW → no push, `stall`=0; OUTPUTB unchanged.
